// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: exponent compare and significand alignment sequencer for the
// 32-bit FP adder. Picks the larger exponent, right-shifts the smaller
// significand by the exponent difference at most STEP bits per clock while
// accumulating guard/round/sticky, then offers both aligned significands to
// the mantissa add stage over a valid/ready handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// CMP   | compare exponents, load significands, pick shift/flush/none
// SHIFT | shift smaller significand by min(rem, STEP), fold lost bits
// DONE  | out_valid high, outputs frozen until out_ready is sampled
module fp_align_ctrl #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int STEP      = 4,
    localparam int W        = SIG_WIDTH + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_WIDTH-1:0] a_exp,
    input  logic [EXP_WIDTH-1:0] b_exp,
    input  logic [SIG_WIDTH-1:0] a_sig,
    input  logic [SIG_WIDTH-1:0] b_sig,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic [W-1:0]         big_sig,
    output logic [W-1:0]         small_sig,
    output logic                 a_is_small,
    output logic                 busy
);

    localparam logic [EXP_WIDTH-1:0] STEP_E = EXP_WIDTH'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [EXP_WIDTH-1:0] a_exp_q;
    logic [EXP_WIDTH-1:0] b_exp_q;
    logic [SIG_WIDTH-1:0] a_sig_q;
    logic [SIG_WIDTH-1:0] b_sig_q;
    logic [EXP_WIDTH-1:0] rem;

    logic                 a_small_c;
    logic [EXP_WIDTH-1:0] big_exp_c;
    logic [EXP_WIDTH-1:0] diff_c;
    logic [SIG_WIDTH-1:0] big_c;
    logic [SIG_WIDTH-1:0] small_c;
    logic                 flush_c;

    logic [EXP_WIDTH-1:0] step_c;
    logic [EXP_WIDTH-1:0] rem_next_c;
    logic [W-1:0]         lost_mask_c;
    logic [W-1:0]         shifted_c;

    // Exponent compare on the latched operands; ties make operand a the small one.
    always_comb begin
        a_small_c = (a_exp_q <= b_exp_q);
        big_exp_c = a_exp_q;
        diff_c    = a_exp_q - b_exp_q;
        big_c     = a_sig_q;
        small_c   = b_sig_q;
        if (a_small_c) begin
            big_exp_c = b_exp_q;
            diff_c    = b_exp_q - a_exp_q;
            big_c     = b_sig_q;
            small_c   = a_sig_q;
        end
        // Differences of W or more shift every significand bit out; only sticky survives.
        flush_c = (32'(diff_c) >= W);
    end

    // One alignment step: shift by min(rem, STEP) and fold every dropped bit into sticky.
    always_comb begin
        step_c      = (rem < STEP_E) ? rem : STEP_E;
        rem_next_c  = rem - step_c;
        lost_mask_c = ~({W{1'b1}} << step_c);
        shifted_c   = small_sig >> step_c;
        shifted_c[0] = shifted_c[0] | small_sig[0] | (|(small_sig & lost_mask_c));
    end

    // Sequencer with registered handshake and datapath outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            exp_out    <= '0;
            big_sig    <= '0;
            small_sig  <= '0;
            a_is_small <= 1'b0;
            rem        <= '0;
            a_exp_q    <= '0;
            b_exp_q    <= '0;
            a_sig_q    <= '0;
            b_sig_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_exp_q  <= a_exp;
                        b_exp_q  <= b_exp;
                        a_sig_q  <= a_sig;
                        b_sig_q  <= b_sig;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    a_is_small <= a_small_c;
                    exp_out    <= big_exp_c;
                    big_sig    <= {big_c, 3'b000};
                    rem        <= diff_c;
                    if (diff_c == '0) begin
                        small_sig <= {small_c, 3'b000};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (flush_c) begin
                        small_sig <= {{(W-1){1'b0}}, |small_c};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        small_sig <= {small_c, 3'b000};
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    small_sig <= shifted_c;
                    rem       <= rem_next_c;
                    if (rem_next_c == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_ctrl.sv
// Testbench for fp_align_ctrl: directed cases plus randomized operand pairs
// compared against an arithmetic reference model of the alignment result.
module tb_fp_align_ctrl;

    localparam int EXP_WIDTH = 8;
    localparam int SIG_WIDTH = 24;
    localparam int STEP      = 4;
    localparam int W         = SIG_WIDTH + 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [EXP_WIDTH-1:0] a_exp;
    logic [EXP_WIDTH-1:0] b_exp;
    logic [SIG_WIDTH-1:0] a_sig;
    logic [SIG_WIDTH-1:0] b_sig;
    logic                 out_valid;
    logic                 out_ready;
    logic [EXP_WIDTH-1:0] exp_out;
    logic [W-1:0]         big_sig;
    logic [W-1:0]         small_sig;
    logic                 a_is_small;
    logic                 busy;

    int n_checks = 0;
    int n_pass   = 0;

    fp_align_ctrl #(
        .EXP_WIDTH(EXP_WIDTH),
        .SIG_WIDTH(SIG_WIDTH),
        .STEP     (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_sig     (a_sig),
        .b_sig     (b_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .big_sig   (big_sig),
        .small_sig (small_sig),
        .a_is_small(a_is_small),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: ideal right shift by the exponent difference, sticky = OR of discarded bits.
    task automatic model(input int ae, input int be,
                         input logic [SIG_WIDTH-1:0] as_, input logic [SIG_WIDTH-1:0] bs_,
                         output logic e_small, output logic [EXP_WIDTH-1:0] e_exp,
                         output logic [63:0] e_big, output logic [63:0] e_sml,
                         output int e_lat);
        int          d;
        logic [63:0] x;
        e_small = (ae <= be);
        if (e_small) begin
            e_exp = EXP_WIDTH'(be);
            d     = be - ae;
            e_big = 64'(bs_) * 8;
            x     = 64'(as_) * 8;
        end else begin
            e_exp = EXP_WIDTH'(ae);
            d     = ae - be;
            e_big = 64'(as_) * 8;
            x     = 64'(bs_) * 8;
        end
        if (d >= W) begin
            e_sml = (x != 0) ? 64'd1 : 64'd0;
        end else begin
            e_sml = x >> d;
            if ((x & ((64'd1 << d) - 64'd1)) != 0) e_sml = e_sml | 64'd1;
        end
        if (d == 0 || d >= W) e_lat = 2;
        else e_lat = 2 + (d + STEP - 1) / STEP;
    endtask

    task automatic check_result(input string tag, input logic e_small,
                                input logic [EXP_WIDTH-1:0] e_exp,
                                input logic [63:0] e_big, input logic [63:0] e_sml);
        check({tag, ".out_valid"},  64'(out_valid),  64'd1);
        check({tag, ".a_is_small"}, 64'(a_is_small), 64'(e_small));
        check({tag, ".exp_out"},    64'(exp_out),    64'(e_exp));
        check({tag, ".big_sig"},    64'(big_sig),    e_big);
        check({tag, ".small_sig"},  64'(small_sig),  e_sml);
        check({tag, ".in_ready"},   64'(in_ready),   64'd0);
        check({tag, ".busy"},       64'(busy),       64'd1);
    endtask

    // Issue one operation, measure latency, hold backpressure for `hold` cycles, drain.
    task automatic run_op(input string tag, input int ae, input int be,
                          input logic [SIG_WIDTH-1:0] as_, input logic [SIG_WIDTH-1:0] bs_,
                          input int hold);
        logic                 e_small;
        logic [EXP_WIDTH-1:0] e_exp;
        logic [63:0]          e_big;
        logic [63:0]          e_sml;
        int                   e_lat;
        int                   lat;
        model(ae, be, as_, bs_, e_small, e_exp, e_big, e_sml, e_lat);
        check({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
        a_exp     = EXP_WIDTH'(ae);
        b_exp     = EXP_WIDTH'(be);
        a_sig     = as_;
        b_sig     = bs_;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(e_lat));
        check_result(tag, e_small, e_exp, e_big, e_sml);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_exp    = EXP_WIDTH'($urandom_range(0, 255));
            b_exp    = EXP_WIDTH'($urandom_range(0, 255));
            a_sig    = SIG_WIDTH'($urandom);
            b_sig    = SIG_WIDTH'($urandom);
            @(posedge clk); #1;
            check_result({tag, ".hold"}, e_small, e_exp, e_big, e_sml);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".post_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".post_ready"}, 64'(in_ready),  64'd1);
        check({tag, ".post_busy"},  64'(busy),      64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ae;
        int be;
        int d;
        logic [SIG_WIDTH-1:0] as_;
        logic [SIG_WIDTH-1:0] bs_;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_exp     = '0;
        b_exp     = '0;
        a_sig     = '0;
        b_sig     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready",   64'(in_ready),   64'd1);
        check("rst.out_valid",  64'(out_valid),  64'd0);
        check("rst.busy",       64'(busy),       64'd0);
        check("rst.exp_out",    64'(exp_out),    64'd0);
        check("rst.big_sig",    64'(big_sig),    64'd0);
        check("rst.small_sig",  64'(small_sig),  64'd0);
        check("rst.a_is_small", 64'(a_is_small), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("c1", 130, 127, 24'h800000, 24'hC00000, 0);
        run_op("c2", 127, 127, 24'h900000, 24'hA00000, 0);
        run_op("c3", 100, 140, 24'h800001, 24'h800000, 0);
        run_op("c4a", 20, 11, 24'h800000, 24'h800101, 0);
        run_op("c4b", 20, 11, 24'h800000, 24'h800100, 0);
        run_op("c5", 130, 127, 24'h800000, 24'hC00000, 5);
        run_op("c5n", 11, 20, 24'h800101, 24'h800000, 1);
        run_op("edge_w", 0, 27, 24'h000001, 24'h800000, 0);
        run_op("edge_w1", 26, 0, 24'hFFFFFF, 24'hFFFFFF, 0);

        // Reset while case 4 is in SHIFT aborts it.
        a_exp    = 8'd20;
        b_exp    = 8'd11;
        a_sig    = 24'h800000;
        b_sig    = 24'h800101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.out_valid", 64'(out_valid), 64'd0);
        check("abort.busy",      64'(busy),      64'd0);
        check("abort.in_ready",  64'(in_ready),  64'd1);
        check("abort.small_sig", 64'(small_sig), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort.quiet", 64'(out_valid), 64'd0);
        end
        run_op("c6", 130, 127, 24'h800000, 24'hC00000, 0);

        for (int n = 0; n < 60; n++) begin
            ae = int'($urandom_range(1, 254));
            d  = int'($urandom_range(0, 34));
            if ($urandom_range(0, 1) == 1) be = ae + d;
            else be = ae - d;
            if (be < 0) be = 0;
            if (be > 255) be = 255;
            as_ = SIG_WIDTH'($urandom) | 24'h800000;
            bs_ = SIG_WIDTH'($urandom) | 24'h800000;
            run_op("rnd", ae, be, as_, bs_, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_align_ctrl.md
# fp_align_ctrl

Multi-cycle alignment sequencer for the 32-bit FP adder. It accepts two unpacked operands and runs the exponent comparison: the larger exponent is kept and the smaller operand is the one whose exponent is `<=` the other's (ties select operand a). It then right-shifts the smaller significand by the exponent difference, at most `STEP` bits per clock, and accumulates guard/round/sticky. It presents both aligned significands to the mantissa add stage through a valid/ready handshake.

## Interface
- `EXP_WIDTH`, 8: exponent width.
- `SIG_WIDTH`, 24: significand width, hidden bit included.
- `STEP`, 4: maximum right-shift per cycle, range 1..8.
- Derived: `W = SIG_WIDTH+3` is the aligned width. Significand occupies `[W-1:3]`; guard, round and sticky occupy `[2:0]`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  high only in IDLE.
- `a_exp`, `b_exp`  in  EXP_WIDTH  biased exponents.
- `a_sig`, `b_sig`  in  SIG_WIDTH  significands.
- `out_valid`  out  1  aligned result valid.
- `out_ready`  in  1  downstream accepts the result.
- `exp_out`  out  EXP_WIDTH  larger exponent.
- `big_sig`  out  W  larger operand's significand, `{sig,3'b000}`.
- `small_sig`  out  W  aligned smaller significand, bit 0 = sticky.
- `a_is_small`  out  1  equals `a_exp <= b_exp`.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, CMP, SHIFT, DONE.
- IDLE: `in_ready=1`. When `in_valid` is high, register the operands and go to CMP.
- CMP (one cycle):
  - `a_is_small = (a_exp <= b_exp)`.
  - `exp_out` = the larger exponent.
  - `rem` = unsigned difference, larger minus smaller, computed at EXP_WIDTH width, so it never goes negative.
  - Load `big_sig = {big,3'b0}` and `small_sig = {small,3'b0}`.
  - If `rem==0`, go to DONE.
  - If `rem >= W`, flush: `small_sig = {W-1'b0, |small}`, then go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - `s = min(rem, STEP)`.
  - `small_sig <= (small_sig >> s)`, with bit 0 ORed with every bit shifted out and with the old bit 0.
  - `rem <= rem - s`.
  - When the new `rem` is 0, go to DONE.
- DONE: `out_valid=1`. Outputs hold stable until `out_ready` is sampled high, then go to IDLE.
- `in_valid` is ignored outside IDLE. There is no input buffering, so exactly one operation is in flight.
- Result contract: equal to an ideal shift by `rem` with sticky = OR of every discarded bit.

## Timing
- Reset: state IDLE, `in_ready=1`, `out_valid=0`, `busy=0`. `exp_out`, `big_sig`, `small_sig`, `a_is_small` and `rem` all reset to 0.
- `rst` wins over every other input in the same cycle.
- Reset mid-operation (CMP, SHIFT or DONE) aborts the operation. The next cycle is IDLE with `out_valid=0`, and no result is emitted.
- Latency, counted from the accepting edge (cycle 0) to the first cycle `out_valid` is high:
  - `2` when `rem==0` or the flush path is taken.
  - `2+ceil(rem/STEP)` otherwise.
- Throughput: `in_ready` returns one cycle after the `out_ready` handshake. Back-to-back issue therefore costs latency+1 cycles per operation.
- Backpressure: while `out_valid && !out_ready`, every output is held bit-identical.

## Test plan
Defaults apply: W=27, STEP=4.

1. a_exp=130, b_exp=127, a_sig=0x800000, b_sig=0xC00000 -> a_is_small=0, exp_out=130, big_sig=0x4000000, small_sig=0x0C00000. One SHIFT cycle; out_valid at cycle 3.
2. a_exp=b_exp=127, a_sig=0x900000, b_sig=0xA00000 -> a_is_small=1, exp_out=127, big_sig=0x5000000, small_sig=0x4800000. out_valid at cycle 2.
3. a_exp=100, b_exp=140, a_sig=0x800001, b_sig=0x800000 -> flush path: small_sig=0x0000001, big_sig=0x4000000, exp_out=140. out_valid at cycle 2.
4. a_exp=20, b_exp=11, a_sig=0x800000, b_sig=0x800101 -> rem=9, three SHIFT cycles (4,4,1). small_sig=0x0020005 (sticky set), out_valid at cycle 5. Repeat with b_sig=0x800100 -> small_sig=0x0020004.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and new operands -> outputs stable, in_ready=0. Assert out_ready -> in_ready=1 the next cycle and the next operand is accepted.
6. Assert rst during SHIFT of case 4 -> next cycle IDLE, out_valid=0, busy=0, in_ready=1. Case 1 issued afterwards gives its correct result.
